obstacle_bouncer: RTL

- Parametrised successor to the fixed-rectangle obstacle generator.
- Draws one rectangle that moves at a constant per-frame velocity inside a bounded arena and bounces off the arena walls.
- Runs for a set number of frames, then pulses `done` so the next obstacle in the chain can start.
- Sits in the game RGB pipeline between the background and the mouse overlay, and feeds pixel coordinates to the collision checker.

---
 rtl/obstacle_bouncer.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/obstacle_bouncer.sv
// Moving rectangle obstacle: bounces inside a bounded arena for a fixed number of
// frames, overlays its colour on the RGB stream and reports covered pixel coordinates.
module obstacle_bouncer #(
    parameter int          RECT_W          = 64,
    parameter int          RECT_H          = 48,
    parameter int          ARENA_LEFT      = 312,
    parameter int          ARENA_RIGHT     = 712,
    parameter int          ARENA_TOP       = 284,
    parameter int          ARENA_BOTTOM    = 684,
    parameter int          START_X         = 312,
    parameter int          START_Y         = 284,
    parameter int          SPEED_X         = 3,
    parameter int          SPEED_Y         = 2,
    parameter int          DURATION_FRAMES = 180,
    parameter logic [11:0] COLOR           = 12'hf_0_0,
    parameter logic [3:0]  SELECT_CODE     = 4'b0001
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] hcount_in,
    input  logic [11:0] vcount_in,
    input  logic [11:0] rgb_in,
    input  logic        play_selected,
    input  logic        menu_on,
    input  logic [3:0]  selected,
    input  logic        done_in,
    output logic [11:0] rgb_out,
    output logic [11:0] obstacle_x,
    output logic [11:0] obstacle_y,
    output logic        obstacle_on,
    output logic        done
);

    localparam int CNT_W = (DURATION_FRAMES > 1) ? $clog2(DURATION_FRAMES) : 1;
    localparam logic [CNT_W-1:0] LAST_FRAME = CNT_W'(DURATION_FRAMES - 1);

    localparam logic [12:0] A_LEFT   = 13'(ARENA_LEFT);
    localparam logic [12:0] A_RIGHT  = 13'(ARENA_RIGHT);
    localparam logic [12:0] A_TOP    = 13'(ARENA_TOP);
    localparam logic [12:0] A_BOTTOM = 13'(ARENA_BOTTOM);
    localparam logic [12:0] SIZE_X   = 13'(RECT_W);
    localparam logic [12:0] SIZE_Y   = 13'(RECT_H);
    localparam logic [12:0] STEP_X   = 13'(SPEED_X);
    localparam logic [12:0] STEP_Y   = 13'(SPEED_Y);
    localparam logic [11:0] X0       = 12'(START_X);
    localparam logic [11:0] Y0       = 12'(START_Y);

    typedef enum logic {IDLE, RUN} state_t;

    state_t          state_q, state_d;
    logic [11:0]     pos_x_q, pos_x_d, pos_y_q, pos_y_d;
    logic            dir_x_q, dir_x_d, dir_y_q, dir_y_d;
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [11:0]     rgb_out_q, rgb_out_d;
    logic [11:0]     obstacle_x_q, obstacle_x_d, obstacle_y_q, obstacle_y_d;
    logic            obstacle_on_q, obstacle_on_d;
    logic            done_q, done_d;

    logic            frame_tick;
    logic            covered;
    logic [12:0]     step_x, step_y;

    // One axis of motion; returns {direction_is_positive, new_position}.
    function automatic logic [12:0] axis_step(
        input logic [11:0] pos,
        input logic        fwd,
        input logic [12:0] lo,
        input logic [12:0] hi,
        input logic [12:0] size,
        input logic [12:0] speed
    );
        logic [12:0] p;
        logic [12:0] n;
        logic        d;
        p = {1'b0, pos};
        if (fwd) begin
            if (p + speed + size > hi) begin
                n = hi - size;
                d = 1'b0;
            end else begin
                n = p + speed;
                d = 1'b1;
            end
        end else begin
            if (p < lo + speed) begin
                n = lo;
                d = 1'b1;
            end else begin
                n = p - speed;
                d = 1'b0;
            end
        end
        return {d, n[11:0]};
    endfunction

    assign frame_tick = (hcount_in == 12'd0) && (vcount_in == 12'd0);
    assign step_x     = axis_step(pos_x_q, dir_x_q, A_LEFT, A_RIGHT, SIZE_X, STEP_X);
    assign step_y     = axis_step(pos_y_q, dir_y_q, A_TOP, A_BOTTOM, SIZE_Y, STEP_Y);

    assign covered = (state_q == RUN)
                  && ({1'b0, hcount_in} >= {1'b0, pos_x_q})
                  && ({1'b0, hcount_in} <  {1'b0, pos_x_q} + SIZE_X)
                  && ({1'b0, vcount_in} >= {1'b0, pos_y_q})
                  && ({1'b0, vcount_in} <  {1'b0, pos_y_q} + SIZE_Y);

    always_comb begin
        state_d       = state_q;
        pos_x_d       = pos_x_q;
        pos_y_d       = pos_y_q;
        dir_x_d       = dir_x_q;
        dir_y_d       = dir_y_q;
        frame_cnt_d   = frame_cnt_q;
        rgb_out_d     = rgb_in;
        obstacle_x_d  = 12'd0;
        obstacle_y_d  = 12'd0;
        obstacle_on_d = 1'b0;
        done_d        = 1'b0;

        if (covered) begin
            rgb_out_d     = COLOR;
            obstacle_x_d  = hcount_in;
            obstacle_y_d  = vcount_in;
            obstacle_on_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (done_in && play_selected && (selected == SELECT_CODE)) begin
                    state_d     = RUN;
                    pos_x_d     = X0;
                    pos_y_d     = Y0;
                    dir_x_d     = 1'b1;
                    dir_y_d     = 1'b1;
                    frame_cnt_d = '0;
                end
            end
            RUN: begin
                // Abort wins over completion; position is only updated at frame start.
                if (menu_on || !play_selected) begin
                    state_d     = IDLE;
                    pos_x_d     = X0;
                    pos_y_d     = Y0;
                    dir_x_d     = 1'b1;
                    dir_y_d     = 1'b1;
                    frame_cnt_d = '0;
                end else if (frame_tick) begin
                    pos_x_d = step_x[11:0];
                    dir_x_d = step_x[12];
                    pos_y_d = step_y[11:0];
                    dir_y_d = step_y[12];
                    if (frame_cnt_q == LAST_FRAME) begin
                        done_d      = 1'b1;
                        state_d     = IDLE;
                        frame_cnt_d = '0;
                        pos_x_d     = X0;
                        pos_y_d     = Y0;
                        dir_x_d     = 1'b1;
                        dir_y_d     = 1'b1;
                    end else begin
                        frame_cnt_d = frame_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            pos_x_q       <= X0;
            pos_y_q       <= Y0;
            dir_x_q       <= 1'b1;
            dir_y_q       <= 1'b1;
            frame_cnt_q   <= '0;
            rgb_out_q     <= 12'd0;
            obstacle_x_q  <= 12'd0;
            obstacle_y_q  <= 12'd0;
            obstacle_on_q <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            pos_x_q       <= pos_x_d;
            pos_y_q       <= pos_y_d;
            dir_x_q       <= dir_x_d;
            dir_y_q       <= dir_y_d;
            frame_cnt_q   <= frame_cnt_d;
            rgb_out_q     <= rgb_out_d;
            obstacle_x_q  <= obstacle_x_d;
            obstacle_y_q  <= obstacle_y_d;
            obstacle_on_q <= obstacle_on_d;
            done_q        <= done_d;
        end
    end

    assign rgb_out     = rgb_out_q;
    assign obstacle_x  = obstacle_x_q;
    assign obstacle_y  = obstacle_y_q;
    assign obstacle_on = obstacle_on_q;
    assign done        = done_q;

endmodule
